// File: rtl/data_sram_if.sv
// CPU data-port bus between the MEM stage and the data SRAM responder.
// Request fields travel master->slave; handshake and response travel back.
interface data_sram_if;
  logic        req;
  logic        wr;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        err;
  logic        busy;

  modport master (
    output req, wr, wen, addr, wdata,
    input  addr_ok, data_ok, rdata, err, busy
  );

  modport slave (
    input  req, wr, wen, addr, wdata,
    output addr_ok, data_ok, rdata, err, busy
  );
endinterface

// File: rtl/data_sram_responder.sv
// Single-outstanding data RAM responder with programmable wait states.
// Loads answer with registered rdata; stores commit per byte lane after the response.
module data_sram_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input logic        clk,
  input logic        rst,
  data_sram_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
    $error("data_sram_responder: LATENCY must be within 0..15");
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [3:0]            wen_q, wen_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  oor_q, oor_d;
  logic                  data_ok_q, data_ok_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [31:0]           mem [DEPTH];

  logic                  accept;
  logic                  in_oor;
  logic [DEPTH_LOG2-1:0] in_idx;
  logic                  rd_wr;
  logic                  rd_oor;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  unused_addr;

  assign in_idx      = bus.addr[DEPTH_LOG2+1:2];
  assign in_oor      = |bus.addr[31:DEPTH_LOG2+2];
  assign unused_addr = ^bus.addr[1:0];
  assign accept      = bus.req & (state_q == IDLE) & ~rst;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    wen_d     = wen_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    oor_d     = oor_q;
    data_ok_d = 1'b0;
    rdata_d   = '0;
    err_d     = 1'b0;
    // Request that occupies RESP next cycle: fresh one at zero latency.
    rd_wr     = wr_q;
    rd_oor    = oor_q;
    rd_idx    = idx_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          wr_d    = bus.wr;
          wen_d   = bus.wen;
          idx_d   = in_idx;
          wdata_d = bus.wdata;
          oor_d   = in_oor;
          cnt_d   = 4'(LATENCY);
          if (LATENCY == 0) begin
            state_d = RESP;
            rd_wr   = bus.wr;
            rd_oor  = in_oor;
            rd_idx  = in_idx;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == RESP) begin
      data_ok_d = 1'b1;
      err_d     = rd_oor;
      rdata_d   = (rd_wr | rd_oor) ? 32'h0 : mem[rd_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      wen_q     <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      oor_q     <= 1'b0;
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      wen_q     <= wen_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      oor_q     <= oor_d;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Store commits on the edge closing RESP; reset forces IDLE so it drops.
  always_ff @(posedge clk) begin
    if (state_q == RESP && wr_q && !oor_q) begin
      for (int i = 0; i < 4; i++) begin
        if (wen_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign bus.addr_ok = accept;
  assign bus.data_ok = data_ok_q;
  assign bus.rdata   = rdata_q;
  assign bus.err     = err_q;
  assign bus.busy    = (state_q != IDLE) | accept;
endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: transaction model, directed cases, random traffic.
// Extra instances sweep LATENCY over 0, 1, 3 and 15.
`timescale 1ns/1ps
module tb_data_sram_responder;
  localparam int L  = 2;
  localparam int DL = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  data_sram_if bus();
  data_sram_responder #(.DEPTH_LOG2(DL), .LATENCY(L)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  function automatic int sw_lat(input int g);
    return (g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 15;
  endfunction

  logic sw_req = 1'b0;
  logic sw_aok  [4];
  logic sw_dok  [4];
  logic sw_busy [4];

  for (genvar g = 0; g < 4; g++) begin : g_sw
    data_sram_if sif();
    assign sif.req   = sw_req;
    assign sif.wr    = 1'b0;
    assign sif.wen   = 4'h0;
    assign sif.addr  = 32'h0;
    assign sif.wdata = 32'h0;
    assign sw_aok[g]  = sif.addr_ok;
    assign sw_dok[g]  = sif.data_ok;
    assign sw_busy[g] = sif.busy;
    data_sram_responder #(.DEPTH_LOG2(DL), .LATENCY(sw_lat(g))) u_sw (
      .clk(clk), .rst(rst), .bus(sif.slave)
    );
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h required %08h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: one outstanding request, due L+1 cycles later.
  logic [31:0] m_mem [1024];
  logic [3:0]  m_kn  [1024];
  bit          pend = 0;
  int          due;
  bit          p_wr, p_err;
  logic [3:0]  p_wen;
  int          p_idx;
  logic [31:0] p_wdata;
  logic [31:0] e_dat, e_msk;

  always @(negedge clk) begin
    if (rst) begin
      pend = 0;
      chk("rst_addr_ok", bus.addr_ok, 0);
      chk("rst_data_ok", bus.data_ok, 0);
      chk("rst_rdata", bus.rdata, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_busy", bus.busy, 0);
    end else if (pend) begin
      chk("wait_addr_ok", bus.addr_ok, 0);
      chk("wait_busy", bus.busy, 1);
      chk("data_ok", bus.data_ok, 32'(cyc == due));
      if (cyc == due) begin
        chk("err", bus.err, 32'(p_err));
        if (p_wr || p_err) begin
          chk("rdata_zero", bus.rdata, 0);
        end else begin
          e_msk = {{8{m_kn[p_idx][3]}}, {8{m_kn[p_idx][2]}},
                   {8{m_kn[p_idx][1]}}, {8{m_kn[p_idx][0]}}};
          e_dat = m_mem[p_idx];
          chk("rdata", bus.rdata & e_msk, e_dat & e_msk);
        end
        if (p_wr && !p_err) begin
          for (int i = 0; i < 4; i++) begin
            if (p_wen[i]) begin
              m_mem[p_idx][8*i +: 8] = p_wdata[8*i +: 8];
              m_kn[p_idx][i] = 1'b1;
            end
          end
        end
        pend = 0;
      end else begin
        chk("idle_rdata", bus.rdata, 0);
        chk("idle_err", bus.err, 0);
      end
    end else begin
      chk("addr_ok", bus.addr_ok, 32'(bus.req));
      chk("busy", bus.busy, 32'(bus.req));
      chk("nodata_ok", bus.data_ok, 0);
      chk("nodata_rdata", bus.rdata, 0);
      chk("nodata_err", bus.err, 0);
      if (bus.req) begin
        pend    = 1;
        due     = cyc + L + 1;
        p_wr    = bus.wr;
        p_wen   = bus.wen;
        p_wdata = bus.wdata;
        p_err   = (bus.addr >> (DL + 2)) != 0;
        p_idx   = int'((bus.addr >> 2) & 32'h3FF);
      end
    end
  end

  task automatic issue(input bit w, input logic [3:0] be,
                       input logic [31:0] a, input logic [31:0] d,
                       output int acc);
    int n = 0;
    bus.req = 1'b1; bus.wr = w; bus.wen = be;
    bus.addr = a; bus.wdata = d;
    @(negedge clk);
    while (!bus.addr_ok && n < 40) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    checks++;
    if (!bus.addr_ok) begin
      failures++;
      $display("FAIL issue_timeout: addr_ok=0 required 1 (addr %08h)", a);
    end
    @(posedge clk); #1;
  endtask

  task automatic get_resp(output logic [31:0] d, output logic e);
    int n = 0;
    @(negedge clk);
    while (!bus.data_ok && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.data_ok) begin
      failures++;
      $display("FAIL resp_timeout: data_ok=0 required 1");
    end
    d = bus.rdata;
    e = bus.err;
    @(posedge clk); #1;
  endtask

  task automatic access(input bit w, input logic [3:0] be,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic e);
    int acc;
    issue(w, be, a, d, acc);
    bus.req = 1'b0;
    get_resp(rd, e);
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        e;
    int          a1, a2, dok, aok;
    logic [31:0] ra;
    for (int i = 0; i < 1024; i++) m_kn[i] = 4'h0;
    bus.req = 0; bus.wr = 0; bus.wen = 0; bus.addr = 0; bus.wdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Latency sweep: one load accepted by all instances at k=0
    sw_req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
        if (k == 0) chk($sformatf("sw%0d_addr_ok", sw_lat(g)), sw_aok[g], 1);
        chk($sformatf("sw%0d_data_ok_k%0d", sw_lat(g), k), sw_dok[g],
            32'(k == sw_lat(g) + 1));
        chk($sformatf("sw%0d_busy_k%0d", sw_lat(g), k), sw_busy[g],
            32'(k <= sw_lat(g) + 1));
      end
      @(posedge clk); #1;
      sw_req = 1'b0;
    end

    // Reset in the middle of a store's wait states
    access(1, 4'hF, 32'h10, 32'h0BADF00D, rd, e);
    issue(1, 4'hF, 32'h10, 32'hDEADBEEF, a1);
    bus.req = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", bus.busy, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    access(0, 4'h0, 32'h10, 0, rd, e);
    chk("rst_mid_load", rd, 32'h0BADF00D);

    // Byte lanes
    access(1, 4'hF, 32'h20, 32'h11223344, rd, e);
    access(1, 4'b0101, 32'h20, 32'hAABBCCDD, rd, e);
    chk("lane_store_rdata", rd, 0);
    access(0, 4'h0, 32'h20, 0, rd, e);
    chk("lane_load", rd, 32'h11BB33DD);

    // Empty lane mask still handshakes, writes nothing
    access(1, 4'h0, 32'h20, 32'hFFFFFFFF, rd, e);
    access(0, 4'h0, 32'h22, 0, rd, e);
    chk("wen0_load", rd, 32'h11BB33DD);

    // Back-to-back with req held high
    issue(1, 4'hF, 32'h40, 32'h5, a1);
    issue(0, 4'h0, 32'h40, 0, a2);
    bus.req = 1'b0;
    get_resp(rd, e);
    chk("b2b_gap", 32'(a2 - a1), 32'(L + 2));
    chk("b2b_load", rd, 32'h5);

    // Out of range
    access(1, 4'hF, 32'h0, 32'h12345678, rd, e);
    access(0, 4'h0, 32'h1000, 0, rd, e);
    chk("oor_load_err", e, 1);
    chk("oor_load_rdata", rd, 0);
    access(1, 4'hF, 32'h1000, 32'hFFFFFFFF, rd, e);
    chk("oor_store_err", e, 1);
    access(0, 4'h0, 32'h0, 0, rd, e);
    chk("oor_alias_word", rd, 32'h12345678);
    chk("oor_alias_err", e, 0);

    // req toggled during WAIT/RESP
    issue(0, 4'h0, 32'h20, 0, a1);
    dok = 0; aok = 0;
    for (int k = 0; k < 6; k++) begin
      bus.req = (k == 0 || k == 2);
      bus.addr = 32'h44;
      @(negedge clk);
      dok += int'(bus.data_ok);
      aok += int'(bus.addr_ok);
      @(posedge clk); #1;
    end
    bus.req = 1'b0;
    chk("toggle_data_ok_count", 32'(dok), 1);
    chk("toggle_addr_ok_count", 32'(aok), 0);

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        ra = $urandom;
        if (ra[31:12] == 0) ra[12] = 1'b1;
      end else begin
        ra = {25'h0, 5'($urandom_range(0, 31)), 2'($urandom)};
      end
      issue(1'($urandom), 4'($urandom), ra, $urandom, a1);
      if ($urandom_range(0, 3) != 0) begin
        bus.req = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end
    bus.req = 1'b0;
    repeat (L + 4) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
